// File: rtl/fxp_pkg.sv
// Shared Q-format constants, saturation limits and FSM state type for the
// fixed-point accumulator.
package fxp_pkg;

  localparam int IN_W_DEF   = 8;
  localparam int FRAC_W_DEF = 4;
  localparam int ACC_W_DEF  = 16;
  localparam int CNT_W      = 8;

  localparam logic [ACC_W_DEF-1:0] ACC_MAX = 16'h7FFF;
  localparam logic [ACC_W_DEF-1:0] ACC_MIN = 16'h8000;
  localparam logic [CNT_W-1:0]     CNT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_HOLD
  } acc_state_t;

endpackage

// File: rtl/fxp_sat_add.sv
// Combinational signed saturating adder: one guard bit detects overflow and
// the result clamps to the most positive / most negative W-bit value.
module fxp_sat_add
  import fxp_pkg::*;
#(
  parameter int W = ACC_W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  localparam logic [W-1:0] SUM_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SUM_MIN = {1'b1, {(W-1){1'b0}}};

  logic [W:0] wide;

  // Overflow whenever the guard bit disagrees with the result sign bit.
  always_comb begin
    wide = {a[W-1], a} + {b[W-1], b};
    ovf  = wide[W] ^ wide[W-1];
    if (ovf) begin
      sum = wide[W] ? SUM_MIN : SUM_MAX;
    end else begin
      sum = wide[W-1:0];
    end
  end

endmodule

// File: rtl/fxp_accum_sat.sv
// Vector accumulator: sums a stream of signed Q4.4 elements into a saturating
// Q12.4 total and holds the result until the consumer takes it.
module fxp_accum_sat
  import fxp_pkg::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_sat,
  output logic [CNT_W-1:0] out_count
);

  // Input and accumulator share the same fraction width, so a plain sign
  // extension aligns the binary points.
  if (ACC_W <= IN_W || FRAC_W >= IN_W) begin : g_param_check
    $error("fxp_accum_sat: need ACC_W > IN_W and FRAC_W < IN_W");
  end

  acc_state_t       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             sat;

  logic [ACC_W-1:0] in_ext;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic [ACC_W-1:0] nxt_acc;
  logic [CNT_W-1:0] nxt_count;
  logic             nxt_sat;

  assign in_ext = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};

  fxp_sat_add #(.W(ACC_W)) u_sat_add (
    .a   (acc),
    .b   (in_ext),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // The first element of a vector starts fresh; later ones add with clamping.
  always_comb begin
    nxt_acc   = in_ext;
    nxt_count = CNT_W'(1);
    nxt_sat   = 1'b0;
    if (state == ST_ACCUM) begin
      nxt_acc   = add_sum;
      nxt_sat   = sat | add_ovf;
      nxt_count = (count == CNT_MAX) ? count : count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      acc       <= '0;
      count     <= '0;
      sat       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_count <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_ACCUM: begin
          if (in_valid && in_ready) begin
            acc   <= nxt_acc;
            count <= nxt_count;
            sat   <= nxt_sat;
            if (in_last) begin
              state     <= ST_HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_data  <= nxt_acc;
              out_sat   <= nxt_sat;
              out_count <= nxt_count;
            end else begin
              state <= ST_ACCUM;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_accum_sat.sv
// Directed, table-driven bench for fxp_accum_sat with hand-computed sums and
// a few multi-cycle sequences for saturation, backpressure, reset and gaps.
module tb_fxp_accum_sat;
  import fxp_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_sat;
  logic [7:0]  out_count;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [3:0][7:0] data;
    int              n;
    logic [15:0]     exp_data;
    logic            exp_sat;
    logic [7:0]      exp_count;
  } vec_t;

  vec_t vecs [5];

  fxp_accum_sat dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Offer one element and wait (bounded) until it is accepted on a clock edge.
  task automatic applyStimulus(input logic [7:0] d, input logic last);
    int waits;
    waits = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && waits < 20) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!in_ready) check("in_ready timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] ed, input logic es,
                             input logic [7:0] ec);
    check({name, " out_valid"}, 32'(out_valid), 32'd1);
    check({name, " out_data"},  32'(out_data),  32'(ed));
    check({name, " out_sat"},   32'(out_sat),   32'(es));
    check({name, " out_count"}, 32'(out_count), 32'(ec));
  endtask

  task automatic consume(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, " idle out_valid"}, 32'(out_valid), 32'd0);
    check({name, " idle in_ready"},  32'(in_ready),  32'd1);
  endtask

  task automatic satRun(input string name, input logic [7:0] d, input int nonlast,
                        input logic [7:0] last_d, input logic [15:0] ed);
    for (int i = 0; i < nonlast; i++) applyStimulus(d, 1'b0);
    check({name, " no early out_valid"}, 32'(out_valid), 32'd0);
    applyStimulus(last_d, 1'b1);
    checkOutput(name, ed, 1'b1, 8'd255);
    consume(name);
  endtask

  initial begin
    logic [15:0] held;

    vecs[0].data = {8'h00, 8'hF0, 8'h18, 8'h18}; vecs[0].n = 3;
    vecs[0].exp_data = 16'h0020; vecs[0].exp_sat = 1'b0; vecs[0].exp_count = 8'd3;
    vecs[1].data = {8'h00, 8'h00, 8'h00, 8'h80}; vecs[1].n = 1;
    vecs[1].exp_data = 16'hFF80; vecs[1].exp_sat = 1'b0; vecs[1].exp_count = 8'd1;
    vecs[2].data = {8'h7F, 8'h7F, 8'h7F, 8'h7F}; vecs[2].n = 4;
    vecs[2].exp_data = 16'h01FC; vecs[2].exp_sat = 1'b0; vecs[2].exp_count = 8'd4;
    vecs[3].data = {8'h00, 8'h00, 8'h10, 8'hF0}; vecs[3].n = 2;
    vecs[3].exp_data = 16'h0000; vecs[3].exp_sat = 1'b0; vecs[3].exp_count = 8'd2;
    vecs[4].data = {8'h00, 8'h80, 8'h80, 8'h80}; vecs[4].n = 3;
    vecs[4].exp_data = 16'hFE80; vecs[4].exp_sat = 1'b0; vecs[4].exp_count = 8'd3;

    // Reset state.
    #12;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data",  32'(out_data),  32'd0);
    check("reset out_count", 32'(out_count), 32'd0);
    check("reset out_sat",   32'(out_sat),   32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    check("reset in_ready", 32'(in_ready), 32'd1);

    for (int v = 0; v < 5; v++) begin
      for (int e = 0; e < vecs[v].n; e++) begin
        check($sformatf("vec%0d pre out_valid", v), 32'(out_valid), 32'd0);
        applyStimulus(vecs[v].data[e], e == vecs[v].n - 1);
      end
      checkOutput($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_sat, vecs[v].exp_count);
      consume($sformatf("vec%0d", v));
    end

    satRun("sat pos", 8'h7F, 299, 8'h7F, ACC_MAX);
    satRun("sat neg", 8'h80, 299, 8'h80, ACC_MIN);
    satRun("sat resume", 8'h7F, 300, 8'h80, 16'h7F7F);

    // Backpressure: input offered throughout HOLD must not be taken.
    applyStimulus(8'h10, 1'b1);
    held = out_data;
    check("bp first out_data", 32'(held), 32'h0010);
    in_valid = 1'b1; in_data = 8'h7F; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp in_ready",  32'(in_ready),  32'd0);
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp out_data",  32'(out_data),  32'(held));
      check("bp out_count", 32'(out_count), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0; in_last = 1'b0;
    check("bp idle out_valid", 32'(out_valid), 32'd0);
    check("bp idle in_ready",  32'(in_ready),  32'd1);

    // Reset in the middle of a vector.
    applyStimulus(8'h10, 1'b0);
    applyStimulus(8'h10, 1'b0);
    #2 resetn = 1'b0;
    #1;
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst out_data",  32'(out_data),  32'd0);
    check("midrst out_sat",   32'(out_sat),   32'd0);
    check("midrst out_count", 32'(out_count), 32'd0);
    @(posedge clk); #3;
    resetn = 1'b1;
    @(posedge clk); #1;
    check("midrst in_ready", 32'(in_ready), 32'd1);
    applyStimulus(8'h10, 1'b1);
    checkOutput("after reset", 16'h0010, 1'b0, 8'd1);
    consume("after reset");

    // Gapped input: junk on the bus while in_valid is low must be ignored.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'h08, i == 3);
      if (i < 3) begin
        in_valid = 1'b0; in_data = 8'h7F; in_last = 1'b1;
        @(posedge clk); #1;
        in_last = 1'b0;
        check("gap out_valid", 32'(out_valid), 32'd0);
      end
    end
    checkOutput("gapped", 16'h0020, 1'b0, 8'd4);
    consume("gapped");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
